// File: rtl/i2c_tx_sequencer.sv
// i2c_tx_sequencer: sequences one I2C write transaction (start + address
// byte, DEPTH-limited payload from a local byte buffer, stop) by issuing
// command strobes to a downstream byte-level I2C master.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-low reset
//   wr_en/wr_addr/wr_data  byte-buffer write port (ignored while busy)
//   go, slave_addr, byte_cnt  transaction request and its parameters
//   m_ready, tx_done   master ready level and byte-complete pulse
//   busy, done, err    transaction status (done/err are one-cycle pulses)
//   bytes_sent         payload bytes completed in current/last transaction
//   tx_data            byte presented to the master
//   start, stop, i2c_en  command strobes to the master
module i2c_tx_sequencer #(
   parameter int unsigned DEPTH = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       wr_en,
   input  logic [2:0] wr_addr,
   input  logic [7:0] wr_data,
   input  logic       go,
   input  logic [6:0] slave_addr,
   input  logic [3:0] byte_cnt,
   input  logic       m_ready,
   input  logic       tx_done,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [3:0] bytes_sent,
   output logic [7:0] tx_data,
   output logic       start,
   output logic       stop,
   output logic       i2c_en
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_WSTART,
      S_WDONE,
      S_WHOLD,
      S_WIDLE
   } state_t;

   state_t     state, state_nx;
   logic [3:0] idx, idx_nx;
   logic [3:0] cnt_q, cnt_nx;
   logic [6:0] addr_q, addr_nx;
   logic [3:0] bytes_sent_nx;
   logic [7:0] tx_data_nx;
   logic       busy_nx, done_nx, err_nx, start_nx, stop_nx, i2c_en_nx;
   logic       widle_first, widle_first_nx;

   logic [7:0] byte_buf [DEPTH];
   logic [3:0] wr_idx;

   assign wr_idx = {1'b0, wr_addr};

   // Payload buffer: writable only while idle, deliberately not reset.
   always_ff @(posedge clk) begin
      if (wr_en && !busy && (32'(wr_idx) < DEPTH)) begin
         byte_buf[AW'(wr_addr)] <= wr_data;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         idx         <= '0;
         cnt_q       <= '0;
         addr_q      <= '0;
         bytes_sent  <= '0;
         tx_data     <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         err         <= 1'b0;
         start       <= 1'b0;
         stop        <= 1'b0;
         i2c_en      <= 1'b0;
         widle_first <= 1'b0;
      end else begin
         state       <= state_nx;
         idx         <= idx_nx;
         cnt_q       <= cnt_nx;
         addr_q      <= addr_nx;
         bytes_sent  <= bytes_sent_nx;
         tx_data     <= tx_data_nx;
         busy        <= busy_nx;
         done        <= done_nx;
         err         <= err_nx;
         start       <= start_nx;
         stop        <= stop_nx;
         i2c_en      <= i2c_en_nx;
         widle_first <= widle_first_nx;
      end
   end

   // Next-state and next-output logic; strobes default low every cycle.
   always_comb begin
      state_nx       = state;
      idx_nx         = idx;
      cnt_nx         = cnt_q;
      addr_nx        = addr_q;
      bytes_sent_nx  = bytes_sent;
      tx_data_nx     = tx_data;
      busy_nx        = busy;
      done_nx        = 1'b0;
      err_nx         = 1'b0;
      start_nx       = 1'b0;
      stop_nx        = 1'b0;
      i2c_en_nx      = 1'b0;
      widle_first_nx = 1'b0;

      // A go while a transaction is running is refused without side effects.
      if (go && (state != S_IDLE)) begin
         err_nx = 1'b1;
      end

      case (state)
         S_IDLE: begin
            if (go) begin
               if (32'(byte_cnt) <= DEPTH) begin
                  addr_nx       = slave_addr;
                  cnt_nx        = byte_cnt;
                  idx_nx        = '0;
                  bytes_sent_nx = '0;
                  busy_nx       = 1'b1;
                  tx_data_nx    = {slave_addr, 1'b0};
                  state_nx      = S_START;
               end else begin
                  err_nx = 1'b1;
               end
            end
         end

         S_START: begin
            tx_data_nx = {addr_q, 1'b0};
            if (m_ready) begin
               start_nx  = 1'b1;
               i2c_en_nx = 1'b1;
               state_nx  = S_WSTART;
            end
         end

         // i2c_en stays high until the master reports ready again.
         S_WSTART: begin
            if (m_ready) begin
               state_nx = S_WDONE;
            end else begin
               i2c_en_nx = 1'b1;
            end
         end

         // Index 0 here means the address byte, which is not payload.
         S_WDONE: begin
            if (tx_done) begin
               state_nx = S_WHOLD;
               if (idx != '0) begin
                  bytes_sent_nx = bytes_sent + 4'd1;
               end
            end
         end

         S_WHOLD: begin
            if (m_ready) begin
               i2c_en_nx = 1'b1;
               if (idx < cnt_q) begin
                  tx_data_nx = byte_buf[AW'(idx)];
                  idx_nx     = idx + 4'd1;
                  state_nx   = S_WDONE;
               end else begin
                  stop_nx        = 1'b1;
                  widle_first_nx = 1'b1;
                  state_nx       = S_WIDLE;
               end
            end
         end

         // First cycle skipped: m_ready may not yet reflect the stop command.
         S_WIDLE: begin
            if (!widle_first && m_ready) begin
               done_nx  = 1'b1;
               busy_nx  = 1'b0;
               state_nx = S_IDLE;
            end
         end

         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_i2c_tx_sequencer.sv
// Directed bench for i2c_tx_sequencer with a small byte-level master model.
module tb_i2c_tx_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       wr_en;
   logic [2:0] wr_addr;
   logic [7:0] wr_data;
   logic       go;
   logic [6:0] slave_addr;
   logic [3:0] byte_cnt;
   logic       m_ready;
   logic       tx_done;
   logic       busy, done, err, start, stop, i2c_en;
   logic [3:0] bytes_sent;
   logic [7:0] tx_data;

   int total = 0;
   int bad   = 0;

   i2c_tx_sequencer #(.DEPTH(8)) dut (
      .clk        (clk),
      .reset      (reset),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .go         (go),
      .slave_addr (slave_addr),
      .byte_cnt   (byte_cnt),
      .m_ready    (m_ready),
      .tx_done    (tx_done),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .bytes_sent (bytes_sent),
      .tx_data    (tx_data),
      .start      (start),
      .stop       (stop),
      .i2c_en     (i2c_en)
   );

   always #5 clk = ~clk;

   // Master model: accepts a command on i2c_en while ready, is busy for two
   // cycles, then (except after stop) pulses tx_done two cycles later.
   logic m_rst;
   int   m_phase;
   int   m_cnt;
   logic m_pend;
   always @(negedge clk) begin
      if (m_rst) begin
         m_ready = 1'b1;
         tx_done = 1'b0;
         m_phase = 0;
         m_cnt   = 0;
         m_pend  = 1'b0;
      end else begin
         tx_done = 1'b0;
         case (m_phase)
            0: if (i2c_en) begin
                  m_ready = 1'b0;
                  m_cnt   = 2;
                  m_pend  = !stop;
                  m_phase = 1;
               end
            1: begin
                  m_cnt = m_cnt - 1;
                  if (m_cnt == 0) begin
                     m_ready = 1'b1;
                     m_cnt   = 2;
                     m_phase = m_pend ? 2 : 0;
                  end
               end
            default: begin
                  m_cnt = m_cnt - 1;
                  if (m_cnt == 0) begin
                     tx_done = 1'b1;
                     m_phase = 0;
                  end
               end
         endcase
      end
   end

   // Command monitor: logs {start,stop,tx_data} at each rising i2c_en and
   // tallies strobe-rule violations.
   logic [9:0] ev_q[$];
   logic       en_prev = 1'b0;
   int         viol    = 0;
   int         n_start = 0;
   always @(negedge clk) begin
      if (i2c_en === 1'b1 && en_prev !== 1'b1) ev_q.push_back({start, stop, tx_data});
      if ((start && stop) || ((start || stop) && !i2c_en)) viol++;
      if (start === 1'b1) n_start++;
      en_prev = i2c_en;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [9:0] ev_at(input int i);
      return (ev_q.size() > i) ? ev_q[i] : 10'h3FF;
   endfunction

   task automatic write_buf(input logic [2:0] a, input logic [7:0] d);
      wr_en = 1'b1; wr_addr = a; wr_data = d;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic issue_go(input logic [6:0] a, input logic [3:0] n);
      go = 1'b1; slave_addr = a; byte_cnt = n;
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      chk({tag, "_done"}, 32'(done), 32'd1);
   endtask

   // Returns at the negedge where i2c_en first falls after the start strobe,
   // i.e. with the sequencer waiting for tx_done of the address byte.
   task automatic wait_wdone(input string tag);
      int n = 0;
      logic seen = 1'b0;
      while (n < 100 && !(seen && i2c_en === 1'b0)) begin
         if (i2c_en === 1'b1) seen = 1'b1;
         @(negedge clk); n++;
      end
      chk({tag, "_wdone"}, 32'(seen && i2c_en === 1'b0), 32'd1);
   endtask

   initial begin
      int s0;
      reset = 1'b0; m_rst = 1'b1;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      go = 1'b0; slave_addr = '0; byte_cnt = '0;

      // Reset held 3 cycles: everything idle.
      repeat (3) @(negedge clk);
      chk("rst_outs", {26'd0, busy, done, err, start, stop, i2c_en}, 32'd0);
      chk("rst_tx_data", 32'(tx_data), 32'h00);
      chk("rst_bytes_sent", 32'(bytes_sent), 32'd0);
      reset = 1'b1; m_rst = 1'b0;
      @(negedge clk);

      // Two-byte write to 0x50.
      write_buf(3'd0, 8'hA5);
      write_buf(3'd1, 8'h3C);
      ev_q.delete();
      issue_go(7'h50, 4'd2);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_bytes_clr", 32'(bytes_sent), 32'd0);
      wait_done("t1");
      chk("t1_busy_end", 32'(busy), 32'd0);
      chk("t1_bytes_sent", 32'(bytes_sent), 32'd2);
      chk("t1_nev", 32'(ev_q.size()), 32'd4);
      chk("t1_ev0", 32'(ev_at(0)), 32'h2A0);
      chk("t1_ev1", 32'(ev_at(1)), 32'h0A5);
      chk("t1_ev2", 32'(ev_at(2)), 32'h03C);
      chk("t1_ev3_stop", 32'(ev_at(3) >> 8), 32'd1);
      @(negedge clk);
      chk("t1_done_pulse", 32'(done), 32'd0);

      // Address only.
      ev_q.delete();
      issue_go(7'h50, 4'd0);
      wait_done("t2");
      chk("t2_bytes_sent", 32'(bytes_sent), 32'd0);
      chk("t2_nev", 32'(ev_q.size()), 32'd2);
      chk("t2_ev0", 32'(ev_at(0)), 32'h2A0);
      chk("t2_ev1", 32'(ev_at(1)), 32'h1A0);
      @(negedge clk);

      // Rejected go (byte_cnt beyond DEPTH).
      s0 = n_start;
      issue_go(7'h50, 4'd9);
      chk("t3_err", 32'(err), 32'd1);
      chk("t3_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("t3_err_pulse", 32'(err), 32'd0);
      repeat (3) @(negedge clk);
      chk("t3_no_start", 32'(n_start - s0), 32'd0);
      chk("t3_idle", {29'd0, busy, i2c_en, start}, 32'd0);

      // Busy collision: go and buffer write while waiting on the address byte.
      ev_q.delete();
      issue_go(7'h50, 4'd2);
      wait_wdone("t4");
      go = 1'b1; slave_addr = 7'h11; byte_cnt = 4'd1;
      wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hFF;
      @(negedge clk);
      go = 1'b0; wr_en = 1'b0;
      chk("t4_err", 32'(err), 32'd1);
      chk("t4_busy", 32'(busy), 32'd1);
      wait_done("t4");
      chk("t4_bytes_sent", 32'(bytes_sent), 32'd2);
      chk("t4_ev0", 32'(ev_at(0)), 32'h2A0);
      chk("t4_ev1", 32'(ev_at(1)), 32'h0A5);
      chk("t4_ev2", 32'(ev_at(2)), 32'h03C);
      @(negedge clk);

      // Mid-transaction reset, then a fresh transaction (buffer must survive).
      ev_q.delete();
      issue_go(7'h50, 4'd2);
      wait_wdone("t5");
      reset = 1'b0; m_rst = 1'b1;
      @(negedge clk);
      chk("t5_rst_outs", {26'd0, busy, done, err, start, stop, i2c_en}, 32'd0);
      chk("t5_rst_tx", 32'(tx_data), 32'h00);
      reset = 1'b1; m_rst = 1'b0;
      @(negedge clk);
      ev_q.delete();
      issue_go(7'h50, 4'd2);
      chk("t5_busy", 32'(busy), 32'd1);
      wait_done("t5");
      chk("t5_bytes_sent", 32'(bytes_sent), 32'd2);
      chk("t5_ev0", 32'(ev_at(0)), 32'h2A0);
      chk("t5_ev1", 32'(ev_at(1)), 32'h0A5);
      chk("t5_ev2", 32'(ev_at(2)), 32'h03C);
      chk("t5_ev3_stop", 32'(ev_at(3) >> 8), 32'd1);
      @(negedge clk);

      chk("strobe_rules", 32'(viol), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_tx_sequencer.md
I2C_TX_SEQUENCER -- requirements
Module: i2c_tx_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Parameter DEPTH, default 8, SHALL set the number of payload bytes held in the byte buffer.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  synchronous active-low reset (0 = reset).
REQ-005 wr_en  input  1  byte-buffer write strobe.
REQ-006 wr_addr  input  3  byte-buffer write index.
REQ-007 wr_data  input  8  byte-buffer write data.
REQ-008 go  input  1  one-cycle request to start a write transaction.
REQ-009 slave_addr  input  7  7-bit target address, sampled on an accepted go.
REQ-010 byte_cnt  input  4  payload length 0..DEPTH, sampled on an accepted go.
REQ-011 busy  output  1  transaction in progress.
REQ-012 done  output  1  one-cycle pulse at transaction end.
REQ-013 err  output  1  one-cycle pulse when a go is rejected.
REQ-014 bytes_sent  output  4  payload bytes acknowledged by tx_done in the current or last transaction.
REQ-015 tx_data  output  8  byte presented to the downstream I2C master.
REQ-016 start, stop, i2c_en  output  1 each  command strobes to the master.
REQ-017 m_ready, tx_done  input  1 each  master ready level and byte-complete pulse.

Function
REQ-018 The FSM SHALL have the states S_IDLE, S_START, S_WSTART, S_WDONE, S_WHOLD and S_WIDLE.
REQ-019 S_IDLE: a go with byte_cnt<=DEPTH SHALL latch slave_addr and byte_cnt, clear the index and bytes_sent, and enter S_START; busy SHALL be 1 from the next cycle.
REQ-020 S_IDLE: a go with byte_cnt>DEPTH SHALL pulse err for one cycle and leave the state at S_IDLE.
REQ-021 A go outside S_IDLE SHALL pulse err and SHALL NOT affect the transaction.
REQ-022 wr_en SHALL write buf[wr_addr] only while busy=0; writes while busy SHALL be dropped, and wr_addr>=DEPTH SHALL be ignored.
REQ-023 S_START: tx_data SHALL equal {slave_addr,1'b0}; when m_ready=1, start and i2c_en SHALL be 1 for that cycle and the FSM SHALL go to S_WSTART, otherwise it SHALL wait with the strobes at 0.
REQ-024 S_WSTART: i2c_en SHALL be held at 1 with start=stop=0 and tx_data unchanged; on m_ready=1 the FSM SHALL go to S_WDONE.
REQ-025 S_WDONE: i2c_en SHALL be 0; on tx_done=1 the FSM SHALL go to S_WHOLD; if the index is nonzero, bytes_sent SHALL increment.
REQ-026 S_WHOLD with m_ready=1 and index<latched byte_cnt: tx_data SHALL be buf[index], i2c_en SHALL be 1 for one cycle with start=stop=0, the index SHALL increment, and the FSM SHALL go to S_WDONE.
REQ-027 S_WHOLD with m_ready=1 and index==latched byte_cnt: stop and i2c_en SHALL be 1 for one cycle and the FSM SHALL go to S_WIDLE.
REQ-028 S_WIDLE: all strobes SHALL be 0; the FSM SHALL ignore m_ready on the first cycle, then on m_ready=1 it SHALL pulse done, clear busy and return to S_IDLE.
REQ-029 start and stop SHALL never be 1 in the same cycle, and start/stop SHALL never be 1 without i2c_en.
REQ-030 Outside the strobe cycles, start, stop and i2c_en SHALL be 0, except i2c_en in S_WSTART.
REQ-031 byte_cnt=0 SHALL send the address byte only, followed by stop.
REQ-032 The block SHALL NOT sample ACK/NACK; the transaction SHALL always run to completion.

Reset
REQ-033 With reset=0 at a rising edge, the FSM SHALL be S_IDLE, the index and bytes_sent SHALL be 0, and busy, done, err, start, stop, i2c_en and tx_data SHALL be 0 from the next cycle, including mid-transaction.
REQ-034 Buffer contents SHALL NOT be cleared by reset.

Verification
REQ-035 Reset: hold reset=0 for 3 cycles -> all outputs 0, busy=0.
REQ-036 Two-byte write: buf[0]=A5, buf[1]=3C, go with slave_addr=50 and byte_cnt=2, driven against the master model -> tx_data sequence A0, A5, 3C, then a stop strobe, done pulse, bytes_sent=2, busy=0.
REQ-037 Address only: byte_cnt=0 -> one start strobe with tx_data=A0, tx_done, stop strobe, done pulse, bytes_sent=0.
REQ-038 Rejected go: byte_cnt=9 -> err pulse the following cycle, no start strobe, busy stays 0.
REQ-039 Busy collision: go and wr_en (buf[1]=FF) during S_WDONE -> err pulse, transfer bytes unchanged (3C is still sent), buf[1] unchanged.
REQ-040 Mid-transaction reset: reset=0 in S_WDONE -> next cycle idle outputs, and a new go is accepted normally after the master is reset too.
